ysyx_23060240_fetch_ctrl: RTL and testbench
===========================================

# ysyx_23060240_fetch_ctrl

Instruction-fetch sequencer sitting between the core's program-counter logic and the instruction-memory port. It owns the fetch PC and issues one request at a time on a simple request/response memory bus. It hands each returned instruction to decode over a valid/ready handshake and applies redirects (jumps/branches) from execute at any point of a fetch, discarding stale responses.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, fetch PC value loaded on reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  execute requests a PC redirect this cycle.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 2'b00).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  request address (= current fetch PC).
- imem_resp_valid  in  1  response data valid (one per accepted request).
- imem_resp_data  in  32  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts instruction.
- inst  out  32  held instruction word.
- inst_pc  out  32  PC of held instruction.
- pc  out  32  current fetch PC register.

## Operation
- States: S_IDLE, S_REQ, S_WAIT, S_OUT, S_DROP. imem_req_valid = (state==S_REQ); inst_valid = (state==S_OUT); imem_req_addr = pc.
- S_IDLE: entered only by reset; unconditionally -> S_REQ next cycle.
- S_REQ: if redirect_valid, pc <= {redirect_pc[31:2],2'b00}; then if imem_req_ready, -> S_DROP when redirect_valid, else -> S_WAIT; if not ready, stay. The bus permits address change while valid is held without ready.
- S_WAIT: redirect_valid has priority: pc <= redirect target; -> S_REQ if imem_resp_valid same cycle (response discarded), else -> S_DROP. Otherwise on imem_resp_valid: inst <= imem_resp_data, inst_pc <= pc, -> S_OUT.
- S_OUT: transfer when inst_ready. redirect_valid: pc <= target, -> S_REQ; the held instruction is withdrawn (counts as transferred only if inst_ready was high that cycle). No redirect and inst_ready: pc <= pc + 4 (mod 2^32, wraps 0xFFFF_FFFC -> 0), -> S_REQ. Otherwise hold, inst/inst_pc stable.
- S_DROP: on imem_resp_valid discard data, -> S_REQ. redirect_valid here only updates pc (last redirect wins).
- imem_resp_valid outside S_WAIT/S_DROP is ignored (protocol violation, no state change).
- At most one outstanding request at all times.

## Timing
- Reset (async assert, any state): state=S_IDLE, pc=RESET_PC, inst=0, inst_pc=0; imem_req_valid=0, inst_valid=0, imem_req_addr=RESET_PC.
- First imem_req_valid: first rising edge after rst_n deasserts moves to S_REQ; valid high from that cycle.
- Best-case throughput: 3 cycles/instruction (REQ accepted, resp next cycle in WAIT, OUT with inst_ready).
- Response in the same cycle as request acceptance is not supported; earliest response is cycle after acceptance.
- Redirect to new request: 1 cycle from S_REQ/S_OUT/S_WAIT-with-resp; from S_WAIT otherwise waits out the stale response in S_DROP.
- inst/inst_pc change only on S_WAIT->S_OUT transition.

## Structure
- Shared package ysyx_23060240_pkg: state enum (3-bit encoding), XLEN=32, INST_W=32, default RESET_PC constant.
- Single module; no sub-module. Next-PC mux (redirect / pc+4 / hold) and FSM in one file.

## Test plan
- Reset then imem_req_ready=1, resp 1 cycle later with 0x00000013, inst_ready=1 -> imem_req_addr 0x80000000, inst_valid with inst_pc 0x80000000, next request at 0x80000004, 3-cycle cadence.
- inst_ready low 5 cycles in S_OUT -> inst/inst_pc stable, no new request, pc unchanged; ready high -> pc 0x80000004.
- Redirect to 0x80000100 in S_WAIT, resp 2 cycles later with 0xDEADBEEF -> response dropped, inst_valid never high for it, next request at 0x80000100.
- Redirect in S_WAIT coincident with resp_valid -> data discarded, S_REQ next cycle at redirect target.
- redirect_pc 0x80000203 in S_OUT with inst_ready=0 -> inst_valid drops, request at 0x80000200; pc 0xFFFFFFFC + accept -> next request at 0x00000000.
- rst_n asserted in S_WAIT mid-request -> outputs return to reset values immediately, late resp_valid after release ignored, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ysyx_23060240_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060240_pkg
// Description : Shared types and constants for the ysyx_23060240 fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_23060240_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h8000_0000;

  // Fetch sequencer states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_DROP = 3'd4
  } fetch_state_e;

  // Instructions are word aligned; the low two bits of a target are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_23060240_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_23060240_fetch_ctrl
// Description : Instruction-fetch sequencer. Owns the fetch PC, issues one
//               memory request at a time, hands instructions to decode over
//               valid/ready and applies redirects, discarding stale responses.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_23060240_fetch_ctrl
  import ysyx_23060240_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic [XLEN-1:0]   pc
);

  fetch_state_e    state;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] pc_next;
  logic            unused_redirect_lsb;

  assign redirect_tgt        = align_pc(redirect_pc);
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Handshake outputs are pure decodes of the state register.
  assign imem_req_valid = (state == S_REQ);
  assign inst_valid     = (state == S_OUT);
  assign imem_req_addr  = pc;

  // Next-PC mux: redirect wins, sequential advance only when decode takes
  // the held instruction, otherwise hold.
  always_comb begin
    pc_next = pc;
    case (state)
      S_REQ, S_WAIT, S_DROP: begin
        if (redirect_valid) pc_next = redirect_tgt;
      end
      S_OUT: begin
        if (redirect_valid)  pc_next = redirect_tgt;
        else if (inst_ready) pc_next = pc + 32'd4;
      end
      default: pc_next = pc;
    endcase
  end

  // Fetch FSM together with the PC and the held-instruction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      inst    <= '0;
      inst_pc <= '0;
    end else begin
      pc <= pc_next;
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          // A request accepted in the same cycle as a redirect fetched the
          // old address, so its response must be thrown away.
          if (imem_req_ready) state <= redirect_valid ? S_DROP : S_WAIT;
        end
        S_WAIT: begin
          if (redirect_valid) begin
            state <= imem_resp_valid ? S_REQ : S_DROP;
          end else if (imem_resp_valid) begin
            inst    <= imem_resp_data;
            inst_pc <= pc;
            state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (redirect_valid || inst_ready) state <= S_REQ;
        end
        S_DROP: begin
          if (imem_resp_valid) state <= S_REQ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060240_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_23060240_fetch_ctrl
// Description : Directed self-checking bench for the fetch sequencer with an
//               instruction scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_23060240_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  ysyx_23060240_fetch_ctrl #(.RESET_PC(32'h8000_0000)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .pc              (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compare the instruction presented to decode with the scoreboard head.
  task automatic check_out();
    exp_t e;
    chk("inst_valid", 32'(inst_valid), 32'd1);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL sb_underflow observed=empty expected=entry");
    end else begin
      e = exp_q.pop_front();
      chk("inst", inst, e.data);
      chk("inst_pc", inst_pc, e.pc);
    end
  endtask

  // From S_REQ: accept the request, answer one cycle later, land in S_OUT.
  task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data);
    chk("req_valid", 32'(imem_req_valid), 32'd1);
    chk("req_addr", imem_req_addr, addr);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
    chk("wait_inst_valid", 32'(inst_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    exp_q.push_back('{pc: addr, data: data});
    step();
    imem_resp_valid = 1'b0;
    check_out();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, 32'h8000_0000);
    chk({tag, "_pc"}, pc, 32'h8000_0000);
    chk({tag, "_inst"}, inst, 32'h0);
    chk({tag, "_inst_pc"}, inst_pc, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    inst_ready      = 1'b0;

    // Reset state
    step();
    step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Basic fetch with 3-cycle cadence
    do_fetch(32'h8000_0000, 32'h0000_0013);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("seq_pc", pc, 32'h8000_0004);

    // Decode stalls for 5 cycles: everything holds
    do_fetch(32'h8000_0004, 32'h0010_0093);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_inst_valid", 32'(inst_valid), 32'd1);
      chk("stall_inst", inst, 32'h0010_0093);
      chk("stall_inst_pc", inst_pc, 32'h8000_0004);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_pc", pc, 32'h8000_0004);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("after_stall_pc", pc, 32'h8000_0008);
    chk("after_stall_req", 32'(imem_req_valid), 32'd1);

    // Redirect in S_WAIT, stale response arrives two cycles later
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    chk("drop_req_valid", 32'(imem_req_valid), 32'd0);
    chk("drop_pc", pc, 32'h8000_0100);
    step();
    chk("drop_inst_valid", 32'(inst_valid), 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    step();
    imem_resp_valid = 1'b0;
    chk("drop_done_inst_valid", 32'(inst_valid), 32'd0);
    chk("drop_done_req_valid", 32'(imem_req_valid), 32'd1);
    chk("drop_done_addr", imem_req_addr, 32'h8000_0100);

    // Redirect in S_WAIT coincident with the response
    imem_req_ready = 1'b1;
    step();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h8000_0300;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1111_1111;
    step();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    chk("coinc_req_valid", 32'(imem_req_valid), 32'd1);
    chk("coinc_addr", imem_req_addr, 32'h8000_0300);
    chk("coinc_inst_valid", 32'(inst_valid), 32'd0);

    // Misaligned redirect in S_OUT withdraws the held instruction
    do_fetch(32'h8000_0300, 32'h2222_2222);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0203;
    step();
    chk("out_redir_inst_valid", 32'(inst_valid), 32'd0);
    chk("out_redir_req_valid", 32'(imem_req_valid), 32'd1);
    chk("out_redir_addr", imem_req_addr, 32'h8000_0200);

    // Redirect while S_REQ is not accepted changes the address in place
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("req_redir_valid", 32'(imem_req_valid), 32'd1);
    chk("req_redir_addr", imem_req_addr, 32'hFFFF_FFFC);

    // PC wraps from the top of the address space
    do_fetch(32'hFFFF_FFFC, 32'h3333_3333);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);
    chk("wrap_pc", pc, 32'h0000_0000);

    // Redirect with request acceptance: old response is dropped
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0400;
    imem_req_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    chk("acc_redir_req_valid", 32'(imem_req_valid), 32'd0);
    chk("acc_redir_pc", pc, 32'h8000_0400);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h5555_5555;
    step();
    imem_resp_valid = 1'b0;
    chk("acc_redir_inst_valid", 32'(inst_valid), 32'd0);
    chk("acc_redir_addr", imem_req_addr, 32'h8000_0400);

    // Response while in S_REQ is ignored
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h6666_6666;
    step();
    imem_resp_valid = 1'b0;
    chk("stray_req_valid", 32'(imem_req_valid), 32'd1);
    chk("stray_inst_valid", 32'(inst_valid), 32'd0);

    // Asynchronous reset in S_WAIT, late response after release
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("pre_rst_req_valid", 32'(imem_req_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n           = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h7777_7777;
    step();
    imem_resp_valid = 1'b0;
    chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
    chk("restart_inst_valid", 32'(inst_valid), 32'd0);
    do_fetch(32'h8000_0000, 32'h4444_4444);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("restart_next_addr", imem_req_addr, 32'h8000_0004);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
